// File: rtl/dmem_mmio_bridge.sv
// Purpose: decode the dmem port into data RAM and a four-register MMIO window (TX FIFO, status, LEDs, cycle counter).
// Latency: loads are combinational with zero cycles. Stores take effect on the rising edge where wren is high.
// Backpressure: the processor is never stalled. A push to a full TX FIFO drops the byte and sets sticky ovf.
//
// Ports:
//   clock, reset          master clock; asynchronous active-high reset
//   address_dmem/data/wren  word address, store data and store enable from the memory stage
//   q_dmem                load data back to the processor (combinational)
//   ram_address/ram_data/ram_wren/ram_q  data RAM port
//   tx_data/tx_valid/tx_ready            byte stream out of the TX FIFO
//   led                   LED register contents
module dmem_mmio_bridge #(
    parameter int          RAM_ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE      = 32'h0000_1000,
    parameter int          FIFO_DEPTH     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               address_dmem,
    input  logic [31:0]               data,
    input  logic                      wren,
    output logic [31:0]               q_dmem,
    output logic [RAM_ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]               ram_data,
    output logic                      ram_wren,
    input  logic [31:0]               ram_q,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [15:0]               led
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic          in_ram;
    logic          in_mmio;
    logic [31:0]   off;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_led;
    logic          wr_cycle;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          ovf;
    logic [31:0]   cycle_cnt;
    logic [31:0]   status;

    // Address decode. The window offset is computed with a wrapping subtract,
    // so addresses below MMIO_BASE land far outside [0,3] and miss the window.
    assign in_ram  = (address_dmem[31:RAM_ADDR_WIDTH] == '0);
    assign off     = address_dmem - MMIO_BASE;
    assign in_mmio = (off < 32'd4);

    assign wr_txdata = wren & in_mmio & (off[1:0] == 2'd0);
    assign wr_status = wren & in_mmio & (off[1:0] == 2'd1);
    assign wr_led    = wren & in_mmio & (off[1:0] == 2'd2);
    assign wr_cycle  = wren & in_mmio & (off[1:0] == 2'd3);

    assign ram_address = address_dmem[RAM_ADDR_WIDTH-1:0];
    assign ram_data    = data;
    assign ram_wren    = wren & in_ram;

    // The FIFO is full-checked before the edge, so a same-edge pop never makes
    // room for a push into a full FIFO.
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign push       = wr_txdata & ~fifo_full;
    assign pop        = tx_valid & tx_ready;
    assign tx_valid   = ~fifo_empty;
    assign tx_data    = fifo_mem[rd_ptr];

    assign status = {24'b0, 5'(count), ovf, fifo_full, fifo_empty};

    always_comb begin
        q_dmem = 32'b0;
        if (in_ram) begin
            q_dmem = ram_q;
        end else if (in_mmio) begin
            case (off[1:0])
                2'd0:    q_dmem = 32'b0;
                2'd1:    q_dmem = status;
                2'd2:    q_dmem = {16'b0, led};
                default: q_dmem = cycle_cnt;
            endcase
        end
    end

    // Storage needs no reset; count and pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            led       <= 16'b0;
            cycle_cnt <= 32'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Overflow set has priority over a clear on the same edge.
            if (wr_txdata & fifo_full) begin
                ovf <= 1'b1;
            end else if (wr_status & data[2]) begin
                ovf <= 1'b0;
            end

            if (wr_led) begin
                led <= data[15:0];
            end

            if (wr_cycle) begin
                cycle_cnt <= data;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end
endmodule
